// File: rtl/fixed_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiply-accumulate unit.
package fixed_multiplier_pkg;

  localparam int A_W_DEF   = 32;
  localparam int B_W_DEF   = 16;
  localparam int CNT_W_DEF = 5;

  // Encodings match the divider so both units decode state the same way.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/fixed_mul_step.sv
// One shift-add iteration: conditionally add A to the high half, then shift
// the {hi,lo} pair right by one, bringing the sum's LSB into the top of lo.
module fixed_mul_step #(
  parameter int A_W = 32,
  parameter int B_W = 16
) (
  input  logic [A_W:0]   hi_i,
  input  logic [B_W-1:0] lo_i,
  input  logic [A_W-1:0] a_i,
  output logic [A_W:0]   hi_o,
  output logic [B_W-1:0] lo_o
);

  logic [A_W:0] sum;

  // Conditional add on the current multiplier bit, then one-bit right shift.
  always_comb begin
    sum  = lo_i[0] ? (hi_i + {1'b0, a_i}) : hi_i;
    hi_o = {1'b0, sum[A_W:1]};
    lo_o = {sum[0], lo_i[B_W-1:1]};
  end

endmodule

// File: rtl/fixed_multiplier.sv
// Sequential unsigned multiply-accumulate: Product = A*B + C, one multiplier
// bit per clock, followed by a single addend cycle.
module fixed_multiplier
  import fixed_multiplier_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [A_W-1:0]     inMultiplicand,
  input  logic [B_W-1:0]     inMultiplier,
  input  logic [B_W-1:0]     inAddend,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] Product
);

  mul_state_e         state_q, state_d;
  logic [A_W-1:0]     a_q, a_d;
  logic [B_W-1:0]     c_q, c_d;
  logic [A_W:0]       hi_q, hi_d;
  logic [B_W-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [A_W+B_W-1:0] product_q, product_d;

  logic [A_W:0]       hi_step;
  logic [B_W-1:0]     lo_step;

  fixed_mul_step #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_step (
    .hi_i (hi_q),
    .lo_i (lo_q),
    .a_i  (a_q),
    .hi_o (hi_step),
    .lo_o (lo_step)
  );

  // State and datapath registers; async reset clears everything so no
  // partial result can be observed after an abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      c_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      c_q       <= c_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state, operand capture, iteration and final accumulate.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    c_d       = c_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Operands are only looked at when a start is accepted here.
        if (start) begin
          a_d     = inMultiplicand;
          c_d     = inAddend;
          hi_d    = '0;
          lo_d    = inMultiplier;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(B_W - 1)) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        // Max A*B+C fits in A_W+B_W bits, so the top carry bit of hi is zero.
        product_d = {hi_q[A_W-1:0], lo_q} + {{A_W{1'b0}}, c_q};
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_MUL) || (state_q == ST_ADD);
  assign done    = (state_q == ST_DONE);
  assign Product = product_q;

endmodule

// File: tb/tb_fixed_multiplier.sv
// Directed test of the shift-add multiply-accumulate unit.
module tb_fixed_multiplier;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] inMultiplicand;
  logic [15:0] inMultiplier;
  logic [15:0] inAddend;
  logic        busy;
  logic        done;
  logic [47:0] Product;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt;
  int cyc;

  fixed_multiplier dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .inMultiplicand (inMultiplicand),
    .inMultiplier   (inMultiplier),
    .inAddend       (inAddend),
    .busy           (busy),
    .done           (done),
    .Product        (Product)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a start for exactly one active edge; returns just after edge 0.
  task automatic start_job(input logic [31:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clock);
    inMultiplicand = a;
    inMultiplier   = b;
    inAddend       = c;
    start          = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
  endtask

  // Wait for done with a cycle bound; cyc counts edges after edge 0.
  task automatic wait_done(input string tag);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if (busy) busy_cnt++;
    end
    chk({tag, "_done_seen"}, {47'd0, done}, 48'd1);
  endtask

  task automatic run_job(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [47:0] exp);
    start_job(a, b, c);
    wait_done(tag);
    chk({tag, "_latency"}, 48'(cyc), 48'd17);
    chk({tag, "_busy_cycles"}, 48'(busy_cnt), 48'd17);
    chk({tag, "_product"}, Product, exp);
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    inMultiplicand = '0;
    inMultiplier   = '0;
    inAddend       = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_done", {47'd0, done}, 48'd0);
    chk("rst_product", Product, 48'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic vectors
    run_job("t1_basic", 32'd1000, 16'd7, 16'd5, 48'd7005);
    run_job("t2_divrt", 32'd333, 16'd300, 16'd100, 48'd100000);
    run_job("t3_max", 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 48'hFFFF_0000_0000);
    run_job("t4_bzero", 32'h1234_5678, 16'd0, 16'h00AB, 48'h0000_0000_00AB);
    run_job("t4_azero", 32'd0, 16'h1234, 16'h0042, 48'h0000_0000_0042);

    // Start while busy is ignored
    start_job(32'd12, 16'd11, 16'd3);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    inMultiplicand = 32'd999;
    inMultiplier   = 16'd999;
    inAddend       = 16'd999;
    start          = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    inMultiplicand = 32'd77;
    wait_done("t5_ignore");
    chk("t5_ignore_product", Product, 48'd135);

    // Back-to-back from DONE; old product must hold through MUL
    start_job(32'd20000, 16'd50, 16'd7);
    chk("t5_b2b_done_drop", {47'd0, done}, 48'd0);
    chk("t5_b2b_busy", {47'd0, busy}, 48'd1);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    chk("t5_b2b_hold", Product, 48'd135);
    cyc = 0;
    wait_done("t5_b2b");
    chk("t5_b2b_product", Product, 48'd1000007);

    // Async reset mid-MUL
    start_job(32'd5, 16'd5, 16'd5);
    repeat (8) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", {47'd0, busy}, 48'd0);
    chk("t6_rst_done", {47'd0, done}, 48'd0);
    chk("t6_rst_product", Product, 48'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_job("t6_after", 32'hDEAD_BEEF, 16'h0010, 16'h0001, 48'h000D_EADB_EEF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
